// File: rtl/synth_pkg.sv
// Shared constants and types for the voice synthesis datapath.
//   SAMPLE_W        default oscillator sample width
//   WAVE_*          channel index of each oscillator on the wave bus
//   N_WAVES_DEFAULT default number of wave channels
//   xfade_state_t   state encoding of the waveform crossfade selector
package synth_pkg;

    localparam int SAMPLE_W        = 16;

    localparam int WAVE_NOISE      = 0;
    localparam int WAVE_TRI        = 1;
    localparam int WAVE_SAW        = 2;
    localparam int WAVE_SQUARE     = 3;
    localparam int WAVE_SINE       = 4;

    localparam int N_WAVES_DEFAULT = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FADE = 1'b1
    } xfade_state_t;

endpackage

// File: rtl/xfade_mac.sv
// Combinational two-input weighted mix.
//   i_a   old wave sample (signed), weight 2**FADE_LOG2 - i_k
//   i_b   new wave sample (signed), weight i_k
//   i_k   crossfade position, 0 .. 2**FADE_LOG2
//   o_mix (i_a*(2**F - i_k) + i_b*i_k) >>> F, truncated toward -inf
module xfade_mac
    import synth_pkg::*;
#(
    parameter int DATA_W    = SAMPLE_W,
    parameter int FADE_LOG2 = 6
) (
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    input  logic        [FADE_LOG2:0] i_k,
    output logic signed [DATA_W-1:0] o_mix
);

    localparam int PROD_W = DATA_W + FADE_LOG2 + 1;
    localparam int SUM_W  = PROD_W + 1;
    localparam int WPAD   = PROD_W - FADE_LOG2 - 1;

    // Weights sum to 2**F, so the shifted result always fits DATA_W and the
    // final narrowing never wraps.
    function automatic logic signed [DATA_W-1:0] mix_fn(
        input logic signed [DATA_W-1:0]  a,
        input logic signed [DATA_W-1:0]  b,
        input logic        [FADE_LOG2:0] k
    );
        logic        [FADE_LOG2:0] wa;
        logic signed [PROD_W-1:0]  pa;
        logic signed [PROD_W-1:0]  pb;
        logic signed [SUM_W-1:0]   sum;
        wa  = (FADE_LOG2+1)'(1 << FADE_LOG2) - k;
        pa  = $signed({{(FADE_LOG2+1){a[DATA_W-1]}}, a}) * $signed({{WPAD{1'b0}}, wa});
        pb  = $signed({{(FADE_LOG2+1){b[DATA_W-1]}}, b}) * $signed({{WPAD{1'b0}}, k});
        sum = $signed({pa[PROD_W-1], pa}) + $signed({pb[PROD_W-1], pb});
        return DATA_W'(sum >>> FADE_LOG2);
    endfunction

    assign o_mix = mix_fn(i_a, i_b, i_k);

endmodule

// File: rtl/wave_xfade_mux.sv
// Waveform selector with click-free switching between oscillator streams.
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_sample_en  one-cycle sample tick; all state updates happen on ticks
//   i_sel        requested wave index (values >= N_WAVES clamp to N_WAVES-1)
//   i_waves      flat bus, channel c = i_waves[c*DATA_W +: DATA_W]
//   o_data       mixed output sample, registered one clock after the tick
//   o_valid      one-cycle pulse when o_data updates
//   o_busy       crossfade running or a new selection waiting to start
module wave_xfade_mux
    import synth_pkg::*;
#(
    parameter int DATA_W    = SAMPLE_W,
    parameter int N_WAVES   = N_WAVES_DEFAULT,
    parameter int SEL_W     = 3,
    parameter int FADE_LOG2 = 6
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_sample_en,
    input  logic [SEL_W-1:0]            i_sel,
    input  logic [N_WAVES*DATA_W-1:0]   i_waves,
    output logic [DATA_W-1:0]           o_data,
    output logic                        o_valid,
    output logic                        o_busy
);

    localparam int KW = FADE_LOG2 + 1;

    xfade_state_t       state_q, state_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]   old_sel_q, old_sel_d;
    logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
    logic [KW-1:0]      k_q, k_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic [SEL_W-1:0]   eff_sel;
    logic [KW-1:0]      k_inc;
    logic [SEL_W-1:0]   mix_old_sel;
    logic signed [DATA_W-1:0] mix_out;

    // Unused select codes read as silence so the wave array can be indexed
    // by any SEL_W value without range issues.
    logic signed [DATA_W-1:0] wave [2**SEL_W];

    for (genvar c = 0; c < 2**SEL_W; c++) begin : g_wave
        if (c < N_WAVES) begin : g_live
            assign wave[c] = i_waves[c*DATA_W +: DATA_W];
        end else begin : g_zero
            assign wave[c] = '0;
        end
    end

    always_comb begin
        if ({1'b0, i_sel} >= (SEL_W+1)'(N_WAVES)) begin
            eff_sel = SEL_W'(N_WAVES - 1);
        end else begin
            eff_sel = i_sel;
        end
    end

    assign k_inc = k_q + KW'(1);

    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        old_sel_d  = old_sel_q;
        pend_sel_d = pend_sel_q;
        k_d        = k_q;
        valid_d    = 1'b0;
        if (i_sample_en) begin
            valid_d    = 1'b1;
            // During a fade the request only parks here; it is acted on
            // from IDLE on a later tick.
            pend_sel_d = eff_sel;
            case (state_q)
                ST_IDLE: begin
                    if (eff_sel != cur_sel_q) begin
                        old_sel_d = cur_sel_q;
                        cur_sel_d = eff_sel;
                        k_d       = KW'(1);
                        state_d   = ST_FADE;
                    end
                end
                ST_FADE: begin
                    if (k_inc == KW'(1 << FADE_LOG2)) begin
                        k_d     = '0;
                        state_d = ST_IDLE;
                    end else begin
                        k_d = k_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d == ST_FADE) || (pend_sel_d != cur_sel_d);
    end

    // k_d == 0 covers both steady IDLE and the fade's final tick: mixing the
    // current wave with itself yields the pure current sample.
    assign mix_old_sel = (k_d == '0) ? cur_sel_d : old_sel_d;

    xfade_mac #(
        .DATA_W    (DATA_W),
        .FADE_LOG2 (FADE_LOG2)
    ) u_mac (
        .i_a   (wave[mix_old_sel]),
        .i_b   (wave[cur_sel_d]),
        .i_k   (k_d),
        .o_mix (mix_out)
    );

    assign data_d = i_sample_en ? mix_out : data_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cur_sel_q  <= '0;
            old_sel_q  <= '0;
            pend_sel_q <= '0;
            k_q        <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            old_sel_q  <= old_sel_d;
            pend_sel_q <= pend_sel_d;
            k_q        <= k_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;

endmodule
